demux_8ch_sequencer: RTL and testbench

Upstream driver for the 1:8 demultiplexer stage. It accepts an 8-bit data word and an 8-bit channel mask through a valid/ready handshake. It then steps through the enabled channels in ascending order and drives the demux control inputs (enable, serial data bit, 3-bit select) for a programmable number of cycles per channel. A one-cycle done pulse marks the end of each word.

---
 rtl/demux_seq_pkg.sv | 31 +++
 rtl/demux_seq_next_ch.sv | 47 ++++
 rtl/demux_8ch_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_demux_8ch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// -----------------------------------------------------------------------------
// demux_seq_pkg
// Shared types and constants for the 8-channel demux sequencer.
//   state_e   : sequencer FSM states (GAP is only reachable when the design is
//               built with DEMUX_SEQ_GAP_EN defined)
//   NUM_CH    : number of demux channels (8)
//   SEL_W     : demux select width (3)
//   HOLD_W    : hold counter width, wide enough for the largest legal
//               HOLD_CYCLES value (255 -> 8 bits)
//   hold_last : terminal count of the hold counter for a given HOLD_CYCLES
// -----------------------------------------------------------------------------
package demux_seq_pkg;

    localparam int NUM_CH   = 8;
    localparam int SEL_W    = 3;
    localparam int HOLD_MAX = 255;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The counter runs 0 .. HOLD_CYCLES-1 while a channel is driven.
    function automatic logic [HOLD_W-1:0] hold_last(input int hold);
        return HOLD_W'(hold - 1);
    endfunction

endpackage

// File: rtl/demux_seq_next_ch.sv
// -----------------------------------------------------------------------------
// demux_seq_next_ch
// Combinational search for the lowest set mask bit strictly above a given
// channel index. Passing an all-ones index (i.e. -1) returns the first set
// channel of the mask.
// Ports:
//   mask_i     : channel mask, bit i set = channel i is visited
//   cur_idx_i  : current channel, one bit wider than the select so that
//                all-ones can stand for "before channel 0"
//   next_idx_o : lowest set channel above cur_idx_i (0 when none found)
//   found_o    : 1 when such a channel exists
// -----------------------------------------------------------------------------
module demux_seq_next_ch
    import demux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W:0]    cur_idx_i,
    output logic [SEL_W-1:0]  next_idx_o,
    output logic              found_o
);

    // All-ones + 1 wraps to 0, so the first-channel search needs no special case;
    // 7 + 1 = 8 still fits in SEL_W+1 bits and masks out every channel.
    logic [SEL_W:0]    start_idx;
    logic [NUM_CH-1:0] above;

    assign start_idx = cur_idx_i + (SEL_W + 1)'(1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
            assign above[gi] = mask_i[gi] && ((SEL_W + 1)'(gi) >= start_idx);
        end
    endgenerate

    // Scan from the top so the lowest qualifying channel is the one that sticks.
    always_comb begin
        next_idx_o = '0;
        found_o    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (above[i]) begin
                next_idx_o = SEL_W'(i);
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_8ch_sequencer.sv
// -----------------------------------------------------------------------------
// demux_8ch_sequencer
// Upstream driver for a 1:8 demultiplexer. A data word and a channel mask are
// accepted over a valid/ready handshake; the enabled channels are then driven
// in ascending order, HOLD_CYCLES cycles each, and a one-cycle done pulse
// closes the word.
//
// Build option: define DEMUX_SEQ_GAP_EN to insert a one-cycle break-before-make
// gap (Enable_Out=0) between consecutive channels. Without it the GAP state is
// not built and channels are driven back-to-back.
//
// Parameters:
//   HOLD_CYCLES : cycles each enabled channel is driven (1..255)
//   NUM_CH      : channel count, must be 8
// Ports:
//   Clock_In        : clock, rising edge
//   Reset_In        : synchronous active-high reset
//   Word_Valid_In   : word/mask available
//   Word_Ready_Out  : sequencer can accept a word (IDLE or DONE)
//   Data_Word_In    : bit i is the value delivered to channel i
//   Channel_Mask_In : bit i set = channel i is visited
//   Abort_In        : cancel the word in progress (no done pulse)
//   Enable_Out      : demux enable
//   Data_Out        : demux serial data bit (0 whenever Enable_Out=0)
//   Select_Out      : demux select, holds its last driven value when idle
//   Busy_Out        : word in progress (DRIVE or GAP)
//   Done_Out        : one-cycle pulse when a word completes
// All outputs are registered.
// -----------------------------------------------------------------------------
module demux_8ch_sequencer
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_CH      = 8
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic                   Word_Valid_In,
    output logic                   Word_Ready_Out,
    input  logic [NUM_CH-1:0]      Data_Word_In,
    input  logic [NUM_CH-1:0]      Channel_Mask_In,
    input  logic                   Abort_In,
    output logic                   Enable_Out,
    output logic                   Data_Out,
    output logic [SEL_W-1:0]       Select_Out,
    output logic                   Busy_Out,
    output logic                   Done_Out
);

    generate
        if (NUM_CH != 8) begin : g_bad_num_ch
            $error("demux_8ch_sequencer: NUM_CH must be 8");
        end
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
            $error("demux_8ch_sequencer: HOLD_CYCLES must be 1..255");
        end
    endgenerate

    localparam logic [HOLD_W-1:0] HOLD_LAST = hold_last(HOLD_CYCLES);

    // ---------------------------------------------------------------- state
    state_e              state_q,  state_d;
    logic [NUM_CH-1:0]   word_q,   word_d;
    logic [NUM_CH-1:0]   mask_q,   mask_d;
    logic [SEL_W-1:0]    ch_q,     ch_d;
    logic [HOLD_W-1:0]   cnt_q,    cnt_d;

    // Output registers
    logic                enable_q, enable_d;
    logic                data_q,   data_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                ready_q,  ready_d;

    logic                accept;
    logic                hold_done;

    // ------------------------------------------------------ channel search
    logic [SEL_W-1:0]    first_idx, next_idx;
    logic                first_found, next_found;

    // First channel comes straight from the incoming mask so the first drive
    // cycle can follow the accept edge without a bubble.
    demux_seq_next_ch u_first_ch (
        .mask_i     (Channel_Mask_In),
        .cur_idx_i  ('1),
        .next_idx_o (first_idx),
        .found_o    (first_found)
    );

    demux_seq_next_ch u_next_ch (
        .mask_i     (mask_q),
        .cur_idx_i  ({1'b0, ch_q}),
        .next_idx_o (next_idx),
        .found_o    (next_found)
    );

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;

        accept    = ready_q && Word_Valid_In;
        hold_done = (cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    word_d = Data_Word_In;
                    mask_d = Channel_Mask_In;
                    cnt_d  = '0;
                    if (first_found) begin
                        state_d = ST_DRIVE;
                        ch_d    = first_idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DRIVE: begin
                if (Abort_In) begin
                    state_d = ST_IDLE;
                end else if (hold_done) begin
                    if (next_found) begin
                        // ch_d advances now; in the gap build Select_Out still
                        // shows the old channel because it only follows ch
                        // while enabled.
                        ch_d  = next_idx;
                        cnt_d = '0;
`ifdef DEMUX_SEQ_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_DRIVE;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef DEMUX_SEQ_GAP_EN
            ST_GAP: begin
                state_d = Abort_In ? ST_IDLE : ST_DRIVE;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        enable_d = (state_d == ST_DRIVE);
        data_d   = enable_d & word_d[ch_d];
        sel_d    = enable_d ? ch_d : sel_q;
        busy_d   = (state_d == ST_DRIVE) || (state_d == ST_GAP);
        done_d   = (state_d == ST_DONE);
        ready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            mask_q   <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            data_q   <= 1'b0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign Word_Ready_Out = ready_q;
    assign Enable_Out     = enable_q;
    assign Data_Out       = data_q;
    assign Select_Out     = sel_q;
    assign Busy_Out       = busy_q;
    assign Done_Out       = done_q;

endmodule

// File: tb/tb_demux_8ch_sequencer.sv
module tb_demux_8ch_sequencer;

    localparam int H = 4;
`ifdef DEMUX_SEQ_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       Clock_In = 1'b0;
    logic       Reset_In = 1'b1;
    logic       Word_Valid_In = 1'b0;
    logic       Word_Ready_Out;
    logic [7:0] Data_Word_In = '0;
    logic [7:0] Channel_Mask_In = '0;
    logic       Abort_In = 1'b0;
    logic       Enable_Out;
    logic       Data_Out;
    logic [2:0] Select_Out;
    logic       Busy_Out;
    logic       Done_Out;

    demux_8ch_sequencer #(.HOLD_CYCLES(H), .NUM_CH(8)) dut (
        .Clock_In        (Clock_In),
        .Reset_In        (Reset_In),
        .Word_Valid_In   (Word_Valid_In),
        .Word_Ready_Out  (Word_Ready_Out),
        .Data_Word_In    (Data_Word_In),
        .Channel_Mask_In (Channel_Mask_In),
        .Abort_In        (Abort_In),
        .Enable_Out      (Enable_Out),
        .Data_Out        (Data_Out),
        .Select_Out      (Select_Out),
        .Busy_Out        (Busy_Out),
        .Done_Out        (Done_Out)
    );

    always #5 Clock_In = ~Clock_In;

    // One expected output snapshot per cycle: {en, dat, sel, busy, done, ready}
    typedef struct packed {
        logic       en;
        logic       dat;
        logic [2:0] sel;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] model_sel = 3'd0;   // last driven select value
    int         checks = 0;
    int         failures = 0;

    function automatic exp_t obs();
        return {Enable_Out, Data_Out, Select_Out, Busy_Out, Done_Out, Word_Ready_Out};
    endfunction

    // Reference model: list of per-cycle outputs following an accept edge,
    // ending with the done cycle.
    task automatic build_exp(input logic [7:0] w, input logic [7:0] m);
        bit first;
        exp_q.delete();
        first = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                if (!first && GAP)
                    exp_q.push_back({1'b0, 1'b0, model_sel, 1'b1, 1'b0, 1'b0});
                for (int h = 0; h < H; h++)
                    exp_q.push_back({1'b1, w[c], 3'(c), 1'b1, 1'b0, 1'b0});
                model_sel = 3'(c);
                first = 1'b0;
            end
        end
        exp_q.push_back({1'b0, 1'b0, model_sel, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic tick();
        @(posedge Clock_In);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        Reset_In = 1'b1;
        tick();
        tick();
        Reset_In = 1'b0;
        model_sel = 3'd0;
        e = {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_vals got=%b exp=%b", obs(), e);
        end
        tick();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), e);
        end
    endtask

    task automatic test_directed();
        logic [7:0] words [5] = '{8'hA5, 8'hFF, 8'h3C, 8'h5A, 8'h81};
        logic [7:0] masks [5] = '{8'hFF, 8'h82, 8'h00, 8'h01, 8'h80};
        exp_t e;
        for (int t = 0; t < 5; t++) begin
            build_exp(words[t], masks[t]);
            Data_Word_In    = words[t];
            Channel_Mask_In = masks[t];
            Word_Valid_In   = 1'b1;
            tick();
            Word_Valid_In   = 1'b0;
            Data_Word_In    = ~words[t];
            Channel_Mask_In = ~masks[t];
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs() !== exp_q[i]) begin
                    failures++;
                    $display("FAIL directed%0d cyc%0d got=%b exp=%b", t, i + 1, obs(), exp_q[i]);
                end
                tick();
            end
            e = {1'b0, 1'b0, model_sel, 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL directed%0d_idle got=%b exp=%b", t, obs(), e);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] w, m;
        exp_t e;
        for (int t = 0; t < 25; t++) begin
            w = 8'($urandom);
            m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            build_exp(w, m);
            Data_Word_In    = w;
            Channel_Mask_In = m;
            Word_Valid_In   = 1'b1;
            tick();
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs() !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random%0d w=%h m=%h cyc%0d got=%b exp=%b", t, w, m, i + 1, obs(), exp_q[i]);
                end
                // Junk on the inputs while busy must be ignored.
                if (i == exp_q.size() - 1) begin
                    Word_Valid_In = 1'b0;
                end else begin
                    Word_Valid_In   = 1'($urandom);
                    Data_Word_In    = 8'($urandom);
                    Channel_Mask_In = 8'($urandom);
                end
                tick();
            end
            e = {1'b0, 1'b0, model_sel, 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL random%0d_idle got=%b exp=%b", t, obs(), e);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   abort_at;
        bit   seen_done;
        build_exp(8'hA5, 8'hFF);
        abort_at = 3 * H + (GAP ? 3 : 0);   // first cycle on channel 3
        Data_Word_In    = 8'hA5;
        Channel_Mask_In = 8'hFF;
        Word_Valid_In   = 1'b1;
        tick();
        Word_Valid_In   = 1'b0;
        for (int i = 0; i <= abort_at; i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_pre cyc%0d got=%b exp=%b", i + 1, obs(), exp_q[i]);
            end
            if (i == abort_at) Abort_In = 1'b1;
            tick();
        end
        Abort_In  = 1'b0;
        model_sel = 3'd3;
        e = {1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=%b", obs(), e);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done_Out === 1'b1 || Enable_Out === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", seen_done);
        end
        // A following word runs normally.
        build_exp(8'h0F, 8'h24);
        Data_Word_In    = 8'h0F;
        Channel_Mask_In = 8'h24;
        Word_Valid_In   = 1'b1;
        tick();
        Word_Valid_In   = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_after cyc%0d got=%b exp=%b", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen_done;
        build_exp(8'hA5, 8'hFF);
        Data_Word_In    = 8'hA5;
        Channel_Mask_In = 8'hFF;
        Word_Valid_In   = 1'b1;
        tick();
        Word_Valid_In   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL rstmid_pre cyc%0d got=%b exp=%b", i + 1, obs(), exp_q[i]);
            end
            if (i == 2) Reset_In = 1'b1;
            tick();
        end
        Reset_In  = 1'b0;
        model_sel = 3'd0;
        e = {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL rstmid_vals got=%b exp=%b", obs(), e);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done_Out === 1'b1 || Enable_Out === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_done got=%b exp=0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1[$];
        exp_t e2[$];
        exp_t e;
        build_exp(8'hA5, 8'h11);
        e1 = exp_q;
        build_exp(8'h3C, 8'h06);
        e2 = exp_q;
        Data_Word_In    = 8'hA5;
        Channel_Mask_In = 8'h11;
        Word_Valid_In   = 1'b1;
        tick();
        // Valid stays high with the second word; only the DONE cycle takes it.
        Data_Word_In    = 8'h3C;
        Channel_Mask_In = 8'h06;
        for (int i = 0; i < e1.size(); i++) begin
            checks++;
            if (obs() !== e1[i]) begin
                failures++;
                $display("FAIL b2b_w1 cyc%0d got=%b exp=%b", i + 1, obs(), e1[i]);
            end
            tick();
        end
        Word_Valid_In = 1'b0;
        for (int i = 0; i < e2.size(); i++) begin
            checks++;
            if (obs() !== e2[i]) begin
                failures++;
                $display("FAIL b2b_w2 cyc%0d got=%b exp=%b", i + 1, obs(), e2[i]);
            end
            tick();
        end
        e = {1'b0, 1'b0, model_sel, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL b2b_idle got=%b exp=%b", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
